conv_window_sched: RTL and testbench
====================================

# conv_window_sched

Sequencer for the parallel convolution datapath: waits until both the X and F memories report full, then steps the window offset across every valid position (0 to X_SIZE-F_SIZE). Each cycle it captures the combinational MAC sum for the current offset into a 2-entry output buffer and drives it to the downstream master over a valid/ready handshake. When the last result has been accepted, it emits a one-cycle conv_done pulse, which clears the memory write controllers for the next frame.

## Interface
- X_SIZE, 128, number of X samples per frame
- F_SIZE, 32, number of filter taps (F_SIZE <= X_SIZE)
- ACC_SIZE, 21, width of MAC sum and output data
- X_ADDR_WIDTH, $clog2(X_SIZE), width of window_offset
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- xmem_full  input  1  X memory holds a complete frame
- fmem_full  input  1  F memory holds a complete filter
- mac_data_in  input  ACC_SIZE  signed sum for the current window_offset; combinational, same cycle
- window_offset  output  X_ADDR_WIDTH  X read base address fed to the datapath
- m_ready_y  input  1  downstream ready
- m_valid_y  output  1  m_data_out_y valid
- m_data_out_y  output  ACC_SIZE  signed result at the buffer head
- conv_done  output  1  one-cycle pulse after the final output is accepted
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, ARM, RUN, DRAIN, DONE.
- IDLE -> ARM when xmem_full && fmem_full are sampled high.
- ARM -> RUN if both are still high; otherwise ARM -> IDLE. This gives the one-cycle settle that memory readout requires.
- RUN: push = (count < 2) || pop, where pop = m_valid_y && m_ready_y.
  - On push: the buffer writes mac_data_in and window_offset increments.
  - On the push where window_offset == X_SIZE-F_SIZE: window_offset returns to 0 and the state goes RUN -> DRAIN.
- DRAIN: no pushes. DRAIN -> DONE on the edge where the buffer becomes empty.
- DONE: conv_done = 1 for exactly one cycle, then DONE -> IDLE unconditionally.
- xmem_full and fmem_full are ignored outside IDLE and ARM.
- Total outputs per frame: N = X_SIZE-F_SIZE+1 (97 by default). Each output is pushed exactly once, in offset order, with no drops or duplicates.
- Buffer:
  - 2-entry FIFO; count ranges 0..2.
  - m_valid_y = (count != 0); m_data_out_y = head entry, registered.
  - Simultaneous push and pop on a full buffer: count unchanged, order preserved.
  - Simultaneous push and pop on a 1-entry buffer: the new value becomes head on the next cycle.
- Arithmetic: data passes through bit-exact at ACC_SIZE; no saturation or re-extension.
- Reset (any state, mid-frame included):
  - state = IDLE, count = 0, window_offset = 0, m_valid_y = 0, m_data_out_y = 0, conv_done = 0, busy = 0.
  - No partial frame resumes after reset.

## Timing
- Let E0 be the first edge at which both full flags are sampled high in IDLE.
- E0 -> ARM; E1 -> RUN with window_offset = 0; E2 is the first push. m_valid_y is first high after E2.
- With m_ready_y held high:
  - One push and one pop per cycle.
  - Pushes at E2..E(N+1); last pop at E(N+2); DRAIN -> DONE at E(N+2).
  - conv_done is high between E(N+2) and E(N+3); IDLE at E(N+3). For N = 97: conv_done is high between E99 and E100.
- With m_ready_y low:
  - Buffer fills after 2 pushes, then window_offset holds.
  - m_data_out_y and m_valid_y stay stable until accepted.
- Full flags are low by E(N+4) because the write controllers are reset by conv_done. IDLE therefore cannot re-trigger on stale flags.
- All outputs are registered; no combinational path from m_ready_y to m_valid_y or m_data_out_y.

## Test plan
- Ramp data, m_ready_y = 1:
  - Stimulus: both full at E0; mac_data_in = window_offset * 3.
  - Required: 97 outputs 0, 3, ..., 288 on consecutive cycles starting after E2; conv_done single pulse between E99 and E100; busy low from E100.
- Backpressure:
  - Stimulus: m_ready_y toggles 1,0,0,1 repeating.
  - Required: all 97 values in order, no loss; window_offset stalls while count == 2; data held stable while m_valid_y && !m_ready_y.
- ARM abort:
  - Stimulus: xmem_full high for one cycle only, then low.
  - Required: IDLE -> ARM -> IDLE; m_valid_y never asserts; busy high for exactly 1 cycle.
- Mid-frame reset:
  - Stimulus: assert reset asynchronously at output 40, between edges.
  - Required: m_valid_y, window_offset, and busy go to 0 without waiting for an edge; the next frame restarts from offset 0 and produces 97 outputs.
- Signed extremes:
  - Stimulus: mac_data_in = -1048576, then 1048575, alternating.
  - Required: values output bit-exact at 21 bits.
- Back-to-back frames:
  - Stimulus: re-raise both full flags 2 cycles after conv_done.
  - Required: second frame yields 97 outputs; exactly one conv_done per frame.

Source files
------------

// File: rtl/conv_window_sched_if.sv
// Result stream from the convolution sequencer to its downstream consumer.
// The stream is a plain valid/ready handshake carrying one signed MAC sum per beat.
interface conv_window_sched_if #(
  parameter int ACC_SIZE = 21
);
  logic                       m_valid_y;
  logic                       m_ready_y;
  logic signed [ACC_SIZE-1:0] m_data_out_y;

  modport master (output m_valid_y, output m_data_out_y, input m_ready_y);
  modport slave  (input m_valid_y, input m_data_out_y, output m_ready_y);
endinterface

// File: rtl/conv_window_sched.sv
// Window sequencer for the parallel convolution datapath: sweeps window_offset over every
// valid position once both memories are full and streams the MAC sums through a 2-deep buffer.
module conv_window_sched #(
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int ACC_SIZE     = 21,
  parameter int X_ADDR_WIDTH = $clog2(X_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       xmem_full,
  input  logic                       fmem_full,
  input  logic signed [ACC_SIZE-1:0] mac_data_in,
  output logic [X_ADDR_WIDTH-1:0]    window_offset,
  output logic                       conv_done,
  output logic                       busy,
  conv_window_sched_if.master        y
);

  localparam logic [X_ADDR_WIDTH-1:0] LAST_OFFSET = X_ADDR_WIDTH'(X_SIZE - F_SIZE);

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [1:0]                 count;
  logic signed [ACC_SIZE-1:0] head, tail;
  logic                       run_en;
  logic                       push, pop, last_push;
  logic                       mem_ready;

  assign mem_ready      = xmem_full && fmem_full;
  assign y.m_valid_y    = (count != 2'd0);
  assign y.m_data_out_y = head;
  assign pop            = y.m_valid_y && y.m_ready_y;
  assign push           = run_en && ((count != 2'd2) || pop);
  assign last_push      = push && (window_offset == LAST_OFFSET);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_ready) state_nxt = ARM;
      ARM:     state_nxt = mem_ready ? RUN : IDLE;
      RUN:     if (last_push) state_nxt = DRAIN;
      // Leave DRAIN on the edge that pops the final buffered entry
      DRAIN:   if (pop && (count == 2'd1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, all from the state register
  always_comb begin
    run_en    = (state == RUN);
    conv_done = (state == DONE);
    busy      = (state != IDLE);
  end

  // Window offset advances only on accepted pushes and wraps after the final position
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          window_offset <= '0;
    else if (last_push) window_offset <= '0;
    else if (push)      window_offset <= window_offset + 1'b1;
  end

  // Output buffer: head is the registered stream output, tail is the second slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= mac_data_in;
          else               tail <= mac_data_in;
        end
        2'b01: head <= tail;
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= mac_data_in;
          end else begin
            head <= mac_data_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: ramp, backpressure, ARM abort, async reset,
// signed extremes and back-to-back frames.
module tb_conv_window_sched;

  localparam int ACC = 21;
  localparam int N   = 97;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  xmem_full, fmem_full;
  logic signed [ACC-1:0] mac_data_in;
  logic [6:0]            window_offset;
  logic                  conv_done, busy;
  int                    mode;

  int total = 0;
  int bad   = 0;

  int got_n, first_k, last_k, done_k, idle_k, done_cnt;

  conv_window_sched_if #(.ACC_SIZE(ACC)) yif ();

  conv_window_sched #(.X_SIZE(128), .F_SIZE(32), .ACC_SIZE(ACC)) dut (
    .clk           (clk),
    .reset         (reset),
    .xmem_full     (xmem_full),
    .fmem_full     (fmem_full),
    .mac_data_in   (mac_data_in),
    .window_offset (window_offset),
    .conv_done     (conv_done),
    .busy          (busy),
    .y             (yif)
  );

  always #5 clk = ~clk;

  // Combinational datapath stand-in: sum depends only on the current window offset
  always_comb begin
    mac_data_in = '0;
    if (mode == 0) mac_data_in = ACC'(int'(window_offset) * 3);
    else           mac_data_in = window_offset[0] ? 21'sh0FFFFF : 21'sh100000;
  end

  function automatic longint exp_val(input int m, input int i);
    if (m == 0) return longint'(i * 3);
    return (i % 2 == 0) ? -64'sd1048576 : 64'sd1048575;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one frame from IDLE; call at a falling edge. k counts falling edges after E0.
  task automatic run_frame(input int m, input bit bp);
    int     k;
    bit     hold;
    longint held;
    mode = m; got_n = 0; first_k = -1; last_k = -1; done_k = -1; idle_k = -1; done_cnt = 0;
    hold = 1'b0; held = 0;
    xmem_full = 1'b1; fmem_full = 1'b1; yif.m_ready_y = 1'b1;
    @(negedge clk);
    k = 0;
    while (k < 3000 && idle_k < 0) begin
      if (k == 1) begin xmem_full = 1'b0; fmem_full = 1'b0; end
      if (hold) begin
        check("hold_vld", yif.m_valid_y, 1);
        check("hold_dat", yif.m_data_out_y, held);
      end
      yif.m_ready_y = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (busy) check("stall", (int'(window_offset) <= got_n + 2), 1);
      if (yif.m_valid_y) begin
        if (first_k < 0) first_k = k;
        if (yif.m_ready_y) begin
          check("data", yif.m_data_out_y, exp_val(m, got_n));
          got_n++;
          last_k = k;
        end
      end
      hold = yif.m_valid_y && !yif.m_ready_y;
      held = yif.m_data_out_y;
      if (conv_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (!busy && k > 1) idle_k = k;
      if (idle_k < 0) begin
        @(negedge clk);
        k++;
      end
    end
    if (idle_k < 0) check("timeout", 0, 1);
    check("n_out", got_n, N);
    check("done_cnt", done_cnt, 1);
  endtask

  initial begin
    int busy_cyc;
    bit saw_vld;
    bit found;
    mode = 0; reset = 1'b1; xmem_full = 1'b0; fmem_full = 1'b0; yif.m_ready_y = 1'b0;
    #3;
    check("rst_vld", yif.m_valid_y, 0);
    check("rst_busy", busy, 0);
    check("rst_off", window_offset, 0);
    check("rst_done", conv_done, 0);
    check("rst_dat", yif.m_data_out_y, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Ramp with the consumer always ready
    run_frame(0, 1'b0);
    check("ramp_first_k", first_k, 2);
    check("ramp_last_k", last_k, N + 1);
    check("ramp_done_k", done_k, N + 2);
    check("ramp_idle_k", idle_k, N + 3);

    // Backpressure 1,0,0,1
    @(negedge clk);
    run_frame(0, 1'b1);

    // ARM abort: xmem_full only for one sampled edge
    @(negedge clk);
    xmem_full = 1'b1; fmem_full = 1'b1; yif.m_ready_y = 1'b1;
    @(negedge clk);
    xmem_full = 1'b0;
    busy_cyc = 0; saw_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cyc++;
      if (yif.m_valid_y) saw_vld = 1'b1;
      @(negedge clk);
    end
    fmem_full = 1'b0;
    check("abort_busy_cyc", busy_cyc, 1);
    check("abort_vld", saw_vld, 0);
    check("abort_idle", busy, 0);

    // Mid-frame asynchronous reset with output 40 at the head
    mode = 0;
    xmem_full = 1'b1; fmem_full = 1'b1; yif.m_ready_y = 1'b1;
    @(negedge clk); @(negedge clk);
    xmem_full = 1'b0; fmem_full = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (yif.m_valid_y && yif.m_data_out_y == 21'sd120) found = 1'b1;
      else @(negedge clk);
    end
    check("mid_found", found, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_vld", yif.m_valid_y, 0);
    check("mid_off", window_offset, 0);
    check("mid_busy", busy, 0);
    check("mid_dat", yif.m_data_out_y, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    run_frame(0, 1'b0);
    check("mid_restart_first_k", first_k, 2);

    // Signed extremes, then a back-to-back frame
    @(negedge clk);
    run_frame(1, 1'b0);
    @(negedge clk);
    run_frame(1, 1'b1);
    @(negedge clk);
    run_frame(0, 1'b0);
    check("b2b_done_k", done_k, N + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
